pipelined_slice_adder: RTL

- Parametrised successor to the team's 4-bit fast-carry adder slice.
- Performs a WIDTH-bit add as a chain of SLICE-bit adds, one slice per pipeline stage, with the carry registered between stages.
- Throughput is one operation per clock, with valid/ready handshakes on both sides.
- Used wherever a wide add must meet timing, e.g. counter/accumulator datapaths built from cascaded slices.

---
 rtl/pipelined_slice_adder_if.sv | 39 +++
 rtl/pipelined_slice_adder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipelined_slice_adder_if.sv
// Handshake bundle for pipelined_slice_adder: operand side (in_*) and result side (out_*).
// PIPELINED_SLICE_ADDER_SUB_EN adds the per-operation 'sub' mode bit.
interface pipelined_slice_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPELINED_SLICE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef PIPELINED_SLICE_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/pipelined_slice_adder.sv
// WIDTH-bit adder built as a chain of SLICE-bit adds, one slice per pipeline stage.
// Optional subtract mode is enabled by defining PIPELINED_SLICE_ADDER_SUB_EN.
module pipelined_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_slice_adder_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;

  logic en_s;
  logic out_valid_s;

  // Whole pipeline advances together whenever the output register is free or being drained.
  always_comb begin
    en_s = !out_valid_s || bus.out_ready;
  end

  assign bus.in_ready = en_s;

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * SLICE;  // operand bits not yet consumed
    localparam int LO_W  = (k + 1) * SLICE;    // sum bits completed after this stage

    logic [SRC_W-1:0] src_a_s;
    logic [SRC_W-1:0] src_b_s;
    logic             src_valid_s;
    logic             src_carry_s;
    logic             src_sub_s;
    logic [LO_W-1:0]  sum_next_s;
    logic [SLICE-1:0] b_slice_s;
    logic [SLICE:0]   add_s;

    logic             valid_r;
    logic             carry_r;
    logic [LO_W-1:0]  sum_r;

    if (k == 0) begin : g_head
`ifdef PIPELINED_SLICE_ADDER_SUB_EN
      assign src_sub_s   = bus.sub;
`else
      assign src_sub_s   = 1'b0;
`endif
      assign src_a_s     = bus.a;
      assign src_b_s     = bus.b;
      assign src_valid_s = bus.in_valid;
      assign src_carry_s = bus.cin ^ src_sub_s;
      assign sum_next_s  = add_s[SLICE-1:0];
    end else begin : g_body
      assign src_sub_s   = g_stage[k-1].g_skew.sub_r;
      assign src_a_s     = g_stage[k-1].g_skew.a_hi_r;
      assign src_b_s     = g_stage[k-1].g_skew.b_hi_r;
      assign src_valid_s = g_stage[k-1].valid_r;
      assign src_carry_s = g_stage[k-1].carry_r;
      assign sum_next_s  = {add_s[SLICE-1:0], g_stage[k-1].sum_r};
    end

    // Slice adder: subtract mode inverts B here, the +1 enters through the stage-1 carry.
    always_comb begin
      b_slice_s = src_b_s[SLICE-1:0] ^ {SLICE{src_sub_s}};
      add_s     = {1'b0, src_a_s[SLICE-1:0]} + {1'b0, b_slice_s} + {{SLICE{1'b0}}, src_carry_s};
    end

    // Stage register: valid, carry out of this slice and the completed low sum bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= {LO_W{1'b0}};
      end else if (en_s) begin
        valid_r <= src_valid_s;
        carry_r <= add_s[SLICE];
        sum_r   <= sum_next_s;
      end
    end

    if (k < NSLICE - 1) begin : g_skew
      logic [SRC_W-SLICE-1:0] a_hi_r;
      logic [SRC_W-SLICE-1:0] b_hi_r;
      logic                   sub_r;

      // Skew registers carry the untouched upper operand slices and the op mode forward.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_hi_r <= {(SRC_W-SLICE){1'b0}};
          b_hi_r <= {(SRC_W-SLICE){1'b0}};
          sub_r  <= 1'b0;
        end else if (en_s) begin
          a_hi_r <= src_a_s[SRC_W-1:SLICE];
          b_hi_r <= src_b_s[SRC_W-1:SLICE];
          sub_r  <= src_sub_s;
        end
      end
    end else begin : g_tail
      logic msb_carry_s;
      logic ovf_r;

      // Carry into the MSB is recovered from the MSB's own sum bit and its operands.
      always_comb begin
        msb_carry_s = src_a_s[SLICE-1] ^ b_slice_s[SLICE-1] ^ add_s[SLICE-1];
      end

      // Signed overflow flag lives in the output stage beside sum and cout.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (en_s) begin
          ovf_r <= msb_carry_s ^ add_s[SLICE];
        end
      end
    end
  end

  assign out_valid_s   = g_stage[NSLICE-1].valid_r;
  assign bus.out_valid = out_valid_s;
  assign bus.sum       = g_stage[NSLICE-1].sum_r;
  assign bus.cout      = g_stage[NSLICE-1].carry_r;
  assign bus.ovf       = g_stage[NSLICE-1].g_tail.ovf_r;

endmodule
